// File: rtl/fir_coef_sched_if.sv
// Register-side and FIR-side signal bundle for the coefficient scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface fir_coef_sched_if #(
    parameter int NTAPS = 16,
    parameter int CW    = 18,
    parameter int AW    = $clog2(NTAPS)
);
    logic          sw_wr_en;
    logic [AW-1:0] sw_wr_addr;
    logic [CW-1:0] sw_wr_data;
    logic          sw_wr_rdy;
    logic          sw_commit;
    logic          err_clr;
    logic          vblank;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic          coef_swap;
    logic          pending;
    logic          done;
    logic          err_late;

    modport master (
        output sw_wr_en, sw_wr_addr, sw_wr_data,
        output sw_commit, err_clr, vblank,
        input  sw_wr_rdy, coef_we, coef_addr, coef_data,
        input  coef_swap, pending, done, err_late
    );

    modport slave (
        input  sw_wr_en, sw_wr_addr, sw_wr_data,
        input  sw_commit, err_clr, vblank,
        output sw_wr_rdy, coef_we, coef_addr, coef_data,
        output coef_swap, pending, done, err_late
    );
endinterface

// File: rtl/fir_coef_sched.sv
// Shadow coefficient bank that streams into the FIR back bank during
// vertical blank and then requests a front/back bank swap.
module fir_coef_sched #(
    parameter int NTAPS = 16,
    parameter int CW    = 18,
    parameter int AW    = $clog2(NTAPS)
) (
    input logic            clk,
    input logic            rst,
    fir_coef_sched_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LOAD,
        SWAP_WAIT,
        SWAP
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          recommit_q, recommit_d;
    logic          err_late_q, err_late_d;
    logic          vblank_q;
    logic          coef_we_q, coef_we_d;
    logic [AW-1:0] coef_addr_q, coef_addr_d;
    logic [CW-1:0] coef_data_q, coef_data_d;
    logic          coef_swap_q, coef_swap_d;
    logic          done_q, done_d;
    logic [CW-1:0] shadow_q [NTAPS];

    logic vblank_rise;
    logic wr_rdy;

    assign vblank_rise = bus.vblank & ~vblank_q;
    assign wr_rdy      = (state_q == IDLE) || (state_q == ARMED);

    assign bus.sw_wr_rdy = wr_rdy;
    assign bus.pending   = (state_q == ARMED) || (state_q == LOAD) ||
                           (state_q == SWAP_WAIT);
    assign bus.coef_we   = coef_we_q;
    assign bus.coef_addr = coef_addr_q;
    assign bus.coef_data = coef_data_q;
    assign bus.coef_swap = coef_swap_q;
    assign bus.done      = done_q;
    assign bus.err_late  = err_late_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        recommit_d  = recommit_q;
        err_late_d  = err_late_q & ~bus.err_clr;
        coef_we_d   = 1'b0;
        coef_addr_d = coef_addr_q;
        coef_data_d = coef_data_q;
        coef_swap_d = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A rise in the commit cycle is not used; wait for the next one.
                if (bus.sw_commit) state_d = ARMED;
            end
            ARMED: begin
                if (vblank_rise) begin
                    state_d     = LOAD;
                    idx_d       = '0;
                    coef_we_d   = 1'b1;
                    coef_addr_d = '0;
                    coef_data_d = shadow_q[0];
                end
            end
            LOAD: begin
                if (bus.sw_commit) recommit_d = 1'b1;
                if (idx_q == LAST) begin
                    if (bus.vblank) begin
                        state_d     = SWAP;
                        coef_swap_d = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        // Overrun: set wins over a coincident clear.
                        state_d    = SWAP_WAIT;
                        err_late_d = 1'b1;
                    end
                end else begin
                    idx_d       = idx_q + 1'b1;
                    coef_we_d   = 1'b1;
                    coef_addr_d = idx_d;
                    coef_data_d = shadow_q[idx_d];
                end
            end
            SWAP_WAIT: begin
                if (bus.sw_commit) recommit_d = 1'b1;
                if (vblank_rise) begin
                    state_d     = SWAP;
                    coef_swap_d = 1'b1;
                    done_d      = 1'b1;
                end
            end
            SWAP: begin
                recommit_d = 1'b0;
                state_d    = (recommit_q || bus.sw_commit) ? ARMED : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            recommit_q  <= 1'b0;
            err_late_q  <= 1'b0;
            vblank_q    <= 1'b0;
            coef_we_q   <= 1'b0;
            coef_addr_q <= '0;
            coef_data_q <= '0;
            coef_swap_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            recommit_q  <= recommit_d;
            err_late_q  <= err_late_d;
            vblank_q    <= bus.vblank;
            coef_we_q   <= coef_we_d;
            coef_addr_q <= coef_addr_d;
            coef_data_q <= coef_data_d;
            coef_swap_q <= coef_swap_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) shadow_q[i] <= '0;
        end else if (bus.sw_wr_en && wr_rdy) begin
            shadow_q[bus.sw_wr_addr] <= bus.sw_wr_data;
        end
    end
endmodule
